// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback sources.
// Optional forwarding of the committing write onto two read ports: define RF_WB_FWD_EN.
module rf_writeback_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_RegWrite,
  output logic [ADDR_W-1:0]         rf_Rd,
  output logic [DATA_W-1:0]         rf_Write_data,
  output logic [15:0]               grant_cnt
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         fwd_rs1,
  input  logic [ADDR_W-1:0]         fwd_rs2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2
`endif
);

  localparam int                PTR_W     = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_cnt;

  logic              w_xfer;
  logic [PTR_W-1:0]  w_grant;
  logic [PTR_W:0]    w_scan;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [ADDR_W-1:0] w_rd_arr   [NUM_REQ];
  logic [DATA_W-1:0] w_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_rd_arr[gi]   = req_rd[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    w_xfer    = 1'b0;
    w_grant   = '0;
    w_scan    = '0;
    req_ready = '0;
    if (!wb_hold) begin
      // Walk the sources starting at rr_ptr; the first valid one wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
        if (w_scan >= NUM_REQ_W) w_scan = w_scan - NUM_REQ_W;
        if (!w_xfer && req_valid[w_scan[PTR_W-1:0]]) begin
          w_xfer  = 1'b1;
          w_grant = w_scan[PTR_W-1:0];
        end
      end
    end
    if (w_xfer) req_ready[w_grant] = 1'b1;
  end

  assign w_sel_rd   = w_rd_arr[w_grant];
  assign w_sel_data = w_data_arr[w_grant];

  // NOTE: sequential state uses non-blocking '<='; the async reset also drops a write still in the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr <= (w_grant == LAST_IDX) ? '0 : w_grant + PTR_W'(1);
        r_rd     <= w_sel_rd;
        r_data   <= w_sel_data;
        // x0 transfers complete the handshake but never reach the regfile.
        if (w_sel_rd != '0) begin
          r_we <= 1'b1;
          if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign rf_RegWrite   = r_we;
  assign rf_Rd         = r_rd;
  assign rf_Write_data = r_data;
  assign grant_cnt     = r_cnt;

`ifdef RF_WB_FWD_EN
  // Bypass the value being committed this cycle to a same-register read.
  assign fwd_data1 = (r_we && (r_rd == fwd_rs1) && (fwd_rs1 != '0)) ? r_data : rf_rdata1;
  assign fwd_data2 = (r_we && (r_rd == fwd_rs2) && (fwd_rs2 != '0)) ? r_data : rf_rdata2;
`endif

endmodule
